// File: rtl/cnn_layer_sequencer.sv
// Sequencer for a two-layer conv/max-pool pipeline.
//
// Runs conv bank 1, then pool bank 1, then conv bank 2, then pool bank 2. Each
// bank is held in reset until its stage begins. A stage ends when every
// instance in its bank reports done. Conv bank 2 is time-shared across the
// FILTER_N1D layer-1 feature maps: l2_src_sel_o walks through them, and an
// external accumulator sums the conv-2 result for each map. Every wait stage
// has a timeout; if it expires the run is aborted and error_o is set.
//
// Ports
//   clock_i            rising-edge clock
//   reset_i            synchronous, active-high reset
//   start_i            run request; only acted on in IDLE
//   busy_o             high in every state except IDLE
//   done_o             one-cycle pulse when a run completes
//   error_o            sticky timeout flag; cleared by the next accepted start
//   stage_o            current state encoding
//   l1_conv_nreset_o   conv bank-1 run (low holds the bank in reset)
//   l1_conv_done_i     conv bank-1 per-instance done
//   l1_pool_nreset_o   pool bank-1 run
//   l1_pool_done_i     pool bank-1 per-instance done
//   l2_conv_nreset_o   conv bank-2 run
//   l2_conv_done_i     conv bank-2 per-instance done
//   l2_src_sel_o       layer-1 pooled map currently feeding conv bank 2
//   l2_acc_clr_o       clears the bank-2 accumulator
//   l2_acc_en_o        adds the current conv-2 outputs into the accumulator
//   l2_pool_nreset_o   pool bank-2 run
//   l2_pool_done_i     pool bank-2 per-instance done
//
// Every output comes from a register or is decoded from state registers only,
// so no input reaches an output combinationally.
module cnn_layer_sequencer #(
  parameter int unsigned FILTER_N1D = 8,
  parameter int unsigned FILTER_N2D = 16,
  parameter int unsigned TIMEOUT    = 4096,
  parameter int unsigned SEL_W      = $clog2(FILTER_N1D)
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o,
  output logic [2:0]            stage_o,
  output logic                  l1_conv_nreset_o,
  input  logic [FILTER_N1D-1:0] l1_conv_done_i,
  output logic                  l1_pool_nreset_o,
  input  logic [FILTER_N1D-1:0] l1_pool_done_i,
  output logic                  l2_conv_nreset_o,
  input  logic [FILTER_N2D-1:0] l2_conv_done_i,
  output logic [SEL_W-1:0]      l2_src_sel_o,
  output logic                  l2_acc_clr_o,
  output logic                  l2_acc_en_o,
  output logic                  l2_pool_nreset_o,
  input  logic [FILTER_N2D-1:0] l2_pool_done_i
);

  // The stage counter must be able to hold TIMEOUT, where it saturates.
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] TimeoutMax  = CNT_W'(TIMEOUT);
  localparam logic [SEL_W-1:0] SelLast     = SEL_W'(FILTER_N1D - 1);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StClear  = 3'd1,
    StL1Conv = 3'd2,
    StL1Pool = 3'd3,
    StL2Conv = 3'd4,
    StL2Acc  = 3'd5,
    StL2Pool = 3'd6,
    StDone   = 3'd7
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             error_q, error_d;
  logic             l1c_nrst_q, l1c_nrst_d;
  logic             l1p_nrst_q, l1p_nrst_d;
  logic             l2c_nrst_q, l2c_nrst_d;
  logic             l2p_nrst_q, l2p_nrst_d;

  // Stage completion and timeout detection
  logic wait_st;     // current state waits on a bank's done vector
  logic all_done;    // AND-reduction of that bank's done vector
  logic stage_fin;   // stage completes this cycle
  logic timeout_hit; // last allowed cycle passed without completion

  always_comb begin
    wait_st  = 1'b0;
    all_done = 1'b0;
    unique case (state_q)
      StL1Conv: begin
        wait_st  = 1'b1;
        all_done = &l1_conv_done_i;
      end
      StL1Pool: begin
        wait_st  = 1'b1;
        all_done = &l1_pool_done_i;
      end
      StL2Conv: begin
        wait_st  = 1'b1;
        all_done = &l2_conv_done_i;
      end
      StL2Pool: begin
        wait_st  = 1'b1;
        all_done = &l2_pool_done_i;
      end
      default: begin
        wait_st  = 1'b0;
        all_done = 1'b0;
      end
    endcase
  end

  // Done flags are ignored at c=0. A bank's flag can still be high from
  // before its nreset was pulled low, and the first cycle would otherwise
  // see that stale value.
  assign stage_fin   = wait_st && (cnt_q != '0) && all_done;
  assign timeout_hit = wait_st && !stage_fin && (cnt_q == TimeoutLast);

  // Next-state logic. Each nreset is registered and set together with the
  // transition into its stage, so the bank starts running in the stage's
  // first cycle.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    error_d    = error_q;
    l1c_nrst_d = l1c_nrst_q;
    l1p_nrst_d = l1p_nrst_q;
    l2c_nrst_d = l2c_nrst_q;
    l2p_nrst_d = l2p_nrst_q;

    if (timeout_hit) begin
      // Abort: the results are invalid, so every bank is put back in reset.
      state_d    = StIdle;
      error_d    = 1'b1;
      l1c_nrst_d = 1'b0;
      l1p_nrst_d = 1'b0;
      l2c_nrst_d = 1'b0;
      l2p_nrst_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            state_d    = StClear;
            error_d    = 1'b0;
            sel_d      = '0;
            l1c_nrst_d = 1'b0;
            l1p_nrst_d = 1'b0;
            l2c_nrst_d = 1'b0;
            l2p_nrst_d = 1'b0;
          end
        end
        StClear: begin
          state_d    = StL1Conv;
          sel_d      = '0;
          l1c_nrst_d = 1'b1;
        end
        StL1Conv: begin
          if (stage_fin) begin
            state_d    = StL1Pool;
            l1p_nrst_d = 1'b1;
          end
        end
        StL1Pool: begin
          if (stage_fin) begin
            state_d    = StL2Conv;
            l2c_nrst_d = 1'b1;
          end
        end
        StL2Conv: begin
          if (stage_fin) begin
            // Conv bank 2 is held in reset for the accumulate cycle. That
            // rearms it for the next source map.
            state_d    = StL2Acc;
            l2c_nrst_d = 1'b0;
          end
        end
        StL2Acc: begin
          l2c_nrst_d = 1'b1;
          if (sel_q == SelLast) begin
            state_d    = StL2Pool;
            l2p_nrst_d = 1'b1;
          end else begin
            state_d = StL2Conv;
            sel_d   = sel_q + SEL_W'(1);
          end
        end
        StL2Pool: begin
          if (stage_fin) begin
            state_d = StDone;
          end
        end
        StDone: begin
          state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  // The stage counter restarts on every state change and saturates at
  // TIMEOUT. Every transition changes state, including the L2_ACC/L2_CONV
  // loop, so the counter is 0 in the first cycle of every state.
  always_comb begin
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (cnt_q == TimeoutMax) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      sel_q      <= '0;
      error_q    <= 1'b0;
      l1c_nrst_q <= 1'b0;
      l1p_nrst_q <= 1'b0;
      l2c_nrst_q <= 1'b0;
      l2p_nrst_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sel_q      <= sel_d;
      error_q    <= error_d;
      l1c_nrst_q <= l1c_nrst_d;
      l1p_nrst_q <= l1p_nrst_d;
      l2c_nrst_q <= l2c_nrst_d;
      l2p_nrst_q <= l2p_nrst_d;
    end
  end

  // Outputs decoded from the state registers only
  assign stage_o          = state_q;
  assign busy_o           = (state_q != StIdle);
  assign done_o           = (state_q == StDone);
  assign error_o          = error_q;
  assign l1_conv_nreset_o = l1c_nrst_q;
  assign l1_pool_nreset_o = l1p_nrst_q;
  assign l2_conv_nreset_o = l2c_nrst_q;
  assign l2_pool_nreset_o = l2p_nrst_q;
  assign l2_src_sel_o     = sel_q;
  assign l2_acc_en_o      = (state_q == StL2Acc);
  // Clear the accumulator once per run, at the start of the first map.
  assign l2_acc_clr_o     = (state_q == StL2Conv) && (cnt_q == '0) && (sel_q == '0);

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Scoreboard bench for cnn_layer_sequencer.
//
// Behavioural bank models raise their done vector 5 cycles after their nreset
// rises. Accumulator clears, accumulate pulses, done pulses and error edges
// are matched in order against a queue of expected (kind, cycle, sel) events.
// The stimulus process fills that queue.
module tb_cnn_layer_sequencer;

  localparam int N1 = 8;
  localparam int N2 = 16;
  localparam int TO = 50;
  localparam int SW = 3;

  localparam int EvClr  = 0;
  localparam int EvAcc  = 1;
  localparam int EvDone = 2;
  localparam int EvErr  = 3;

  // Done-input modes: bank models, 7-of-8 partial on l1 conv, all tied high
  localparam int ModeModel   = 0;
  localparam int ModePartial = 1;
  localparam int ModeStale   = 2;

  typedef struct {
    int kind;
    int cyc;
    int sel;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          busy, done, error;
  logic [2:0]    stage;
  logic          l1c_nrst, l1p_nrst, l2c_nrst, l2p_nrst;
  logic [N1-1:0] l1c_done, l1p_done;
  logic [N2-1:0] l2c_done, l2p_done;
  logic [SW-1:0] sel;
  logic          acc_clr, acc_en;
  logic [14:0]   outvec;
  logic [3:0]    nrst;

  int  cyc = 0;
  int  mode = ModeModel;
  int  checks = 0;
  int  errors = 0;
  ev_t sb[$];
  logic err_prev = 1'b0;

  int b1c = 0, b1p = 0, b2c = 0, b2p = 0;

  cnn_layer_sequencer #(
    .FILTER_N1D (N1),
    .FILTER_N2D (N2),
    .TIMEOUT    (TO),
    .SEL_W      (SW)
  ) dut (
    .clock_i          (clk),
    .reset_i          (rst),
    .start_i          (start),
    .busy_o           (busy),
    .done_o           (done),
    .error_o          (error),
    .stage_o          (stage),
    .l1_conv_nreset_o (l1c_nrst),
    .l1_conv_done_i   (l1c_done),
    .l1_pool_nreset_o (l1p_nrst),
    .l1_pool_done_i   (l1p_done),
    .l2_conv_nreset_o (l2c_nrst),
    .l2_conv_done_i   (l2c_done),
    .l2_src_sel_o     (sel),
    .l2_acc_clr_o     (acc_clr),
    .l2_acc_en_o      (acc_en),
    .l2_pool_nreset_o (l2p_nrst),
    .l2_pool_done_i   (l2p_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Bank models: count cycles since nreset rose, done from count 5 onward
  always @(posedge clk) begin
    b1c <= l1c_nrst ? ((b1c < 7) ? b1c + 1 : b1c) : 0;
    b1p <= l1p_nrst ? ((b1p < 7) ? b1p + 1 : b1p) : 0;
    b2c <= l2c_nrst ? ((b2c < 7) ? b2c + 1 : b2c) : 0;
    b2p <= l2p_nrst ? ((b2p < 7) ? b2p + 1 : b2p) : 0;
  end

  assign l1c_done = (mode == ModeStale)   ? {N1{1'b1}} :
                    (mode == ModePartial) ? 8'h7F :
                    ((b1c >= 5) ? {N1{1'b1}} : {N1{1'b0}});
  assign l1p_done = (mode == ModeStale || b1p >= 5) ? {N1{1'b1}} : {N1{1'b0}};
  assign l2c_done = (mode == ModeStale || b2c >= 5) ? {N2{1'b1}} : {N2{1'b0}};
  assign l2p_done = (mode == ModeStale || b2p >= 5) ? {N2{1'b1}} : {N2{1'b0}};

  assign nrst   = {l1c_nrst, l1p_nrst, l2c_nrst, l2p_nrst};
  assign outvec = {stage, busy, done, error, nrst, sel, acc_clr, acc_en};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input int c, input int s);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    e.sel  = s;
    sb.push_back(e);
  endtask

  // Expected events of one run started at t0, every wait stage lasting len
  // cycles: clear at the first L2_CONV entry, one accumulate per map, done.
  task automatic push_run(input int t0, input int len, input int nacc, input bit with_done);
    int base;
    base = t0 + 2 + 2 * len;
    push(EvClr, base, 0);
    for (int i = 0; i < nacc; i++) push(EvAcc, base + len + i * (len + 1), i);
    if (with_done) push(EvDone, base + N1 * (len + 1) + len, 0);
  endtask

  task automatic handle(input int kind, input int s);
    ev_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL sb_unexpected: got kind=%0d cyc=%0d sel=%0d expected none", kind, cyc, s);
    end else begin
      e = sb.pop_front();
      if (e.kind != kind || e.cyc != cyc || e.sel != s) begin
        errors++;
        $display("FAIL sb_event: got kind=%0d cyc=%0d sel=%0d expected kind=%0d cyc=%0d sel=%0d",
                 kind, cyc, s, e.kind, e.cyc, e.sel);
      end
    end
  endtask

  // Monitor: sample outputs on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (acc_clr) handle(EvClr, int'(sel));
    if (acc_en) handle(EvAcc, int'(sel));
    if (done) handle(EvDone, 0);
    if (error && !err_prev) handle(EvErr, 0);
    err_prev = error;
  end

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Pulse start for one cycle; t is the cycle in which start is sampled
  task automatic go(output int t);
    t = cyc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected end by 200000");
    $fatal(1);
  end

  initial begin
    int t0;
    int t1;
    rst = 1'b1;
    start = 1'b0;
    mode = ModeModel;
    repeat (3) @(negedge clk);
    chk("reset_state", int'(outvec), 0);

    // A start alongside reset while in IDLE must not start a run
    start = 1'b1;
    @(negedge clk);
    chk("reset_start_stage", int'(stage), 0);
    chk("reset_start_busy", int'(busy), 0);
    start = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", int'(busy), 0);

    // Partial done: 7 of 8 l1 conv bits, timeout after 50 cycles in L1_CONV
    mode = ModePartial;
    go(t0);
    push(EvErr, t0 + 52, 0);
    wait_until(t0 + 51);
    chk("partial_stage_hold", int'(stage), 2);
    chk("partial_no_err_yet", int'(error), 0);
    wait_until(t0 + 52);
    chk("timeout_stage", int'(stage), 0);
    chk("timeout_error", int'(error), 1);
    chk("timeout_nrst", int'(nrst), 0);
    chk("timeout_busy", int'(busy), 0);
    wait_until(t0 + 56);
    mode = ModeModel;

    // Nominal run; clears the sticky error
    go(t0);
    push_run(t0, 6, N1, 1'b1);
    wait_until(t0 + 1);
    chk("nom_clear_stage", int'(stage), 1);
    chk("nom_error_cleared", int'(error), 0);
    chk("nom_clear_nrst", int'(nrst), 0);
    wait_until(t0 + 2);
    chk("nom_l1conv_stage", int'(stage), 2);
    chk("nom_l1conv_nrst", int'(nrst), 4'b1000);
    wait_until(t0 + 76);
    chk("nom_done_stage", int'(stage), 7);
    chk("nom_done_nrst", int'(nrst), 4'b1111);

    // Back-to-back: start in the cycle after DONE
    wait_until(t0 + 77);
    chk("b2b_idle_busy", int'(busy), 0);
    chk("b2b_idle_nrst", int'(nrst), 4'b1111);
    go(t1);
    push_run(t1, 6, N1, 1'b1);
    wait_until(t1 + 1);
    chk("b2b_clear_stage", int'(stage), 1);
    chk("b2b_clear_nrst", int'(nrst), 0);
    wait_until(t1 + 2);
    chk("b2b_l1conv_nrst", int'(nrst), 4'b1000);
    wait_until(t1 + 80);

    // Stale done: every input tied high, each wait stage lasts 2 cycles
    mode = ModeStale;
    go(t0);
    push_run(t0, 2, N1, 1'b1);
    wait_until(t0 + 31);
    chk("stale_l2pool_stage", int'(stage), 6);
    wait_until(t0 + 32);
    chk("stale_done_stage", int'(stage), 7);
    wait_until(t0 + 35);
    mode = ModeModel;

    // start pulsed repeatedly during L2_CONV must be ignored
    go(t0);
    push_run(t0, 6, N1, 1'b1);
    for (int k = 15; k <= 19; k++) begin
      wait_until(t0 + k);
      start = (k % 2 == 1);
    end
    wait_until(t0 + 20);
    start = 1'b0;
    wait_until(t0 + 80);

    // Mid-run reset while conv bank 2 works on map 3
    go(t0);
    push_run(t0, 6, 3, 1'b0);
    wait_until(t0 + 36);
    chk("midrst_stage_before", int'(stage), 4);
    chk("midrst_sel_before", int'(sel), 3);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_outputs", int'(outvec), 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
